slc3_isdu_param: RTL

- Parametrised next-generation instruction sequencer / decode unit for the SLC-3 datapath.
- Moore FSM driving all load, gate, mux and SRAM control strobes.
- Implements the full SLC-3 set: ADD, AND, NOT, BR, JMP, JSR, LDR, STR, PAUSE.
- Adds a configurable SRAM access latency and an optional pause-after-fetch debug mode.

---
 rtl/slc3_pkg.sv | 94 +++++++++
 rtl/slc3_mem_wait_ctr.sv | 51 +++++
 rtl/slc3_isdu_param.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/slc3_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : slc3_pkg                                                    |
// | Description: Shared encodings for the SLC-3 sequencer: opcodes, datapath  |
// |              mux selects, ALU functions, LD/GATE bit positions and the   |
// |              sequencer state type.                                       |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package slc3_pkg;

  // Opcodes (IR[15:12])
  localparam logic [3:0] op_add   = 4'b0001;
  localparam logic [3:0] op_and   = 4'b0101;
  localparam logic [3:0] op_not   = 4'b1001;
  localparam logic [3:0] op_br    = 4'b0000;
  localparam logic [3:0] op_jmp   = 4'b1100;
  localparam logic [3:0] op_jsr   = 4'b0100;
  localparam logic [3:0] op_ldr   = 4'b0110;
  localparam logic [3:0] op_str   = 4'b0111;
  localparam logic [3:0] op_pause = 4'b1101;

  // PC source select
  localparam logic [1:0] c_pcmux_pc1  = 2'b00;
  localparam logic [1:0] c_pcmux_bus  = 2'b01;
  localparam logic [1:0] c_pcmux_addr = 2'b10;

  // Destination / source register selects
  localparam logic c_drmux_ir11 = 1'b0;
  localparam logic c_drmux_r7   = 1'b1;
  localparam logic c_sr1mux_ir11 = 1'b0;
  localparam logic c_sr1mux_ir8  = 1'b1;

  // Address adder operand selects
  localparam logic       c_addr1_pc    = 1'b0;
  localparam logic       c_addr1_sr1   = 1'b1;
  localparam logic [1:0] c_addr2_zero  = 2'b00;
  localparam logic [1:0] c_addr2_off6  = 2'b01;
  localparam logic [1:0] c_addr2_off9  = 2'b10;
  localparam logic [1:0] c_addr2_off11 = 2'b11;

  // ALU functions
  localparam logic [1:0] c_aluk_add  = 2'b00;
  localparam logic [1:0] c_aluk_and  = 2'b01;
  localparam logic [1:0] c_aluk_not  = 2'b10;
  localparam logic [1:0] c_aluk_pass = 2'b11;

  // Bit positions inside the LD vector {MAR, MDR, IR, BEN, CC, REG, PC}
  localparam int unsigned c_ld_mar = 6;
  localparam int unsigned c_ld_mdr = 5;
  localparam int unsigned c_ld_ir  = 4;
  localparam int unsigned c_ld_ben = 3;
  localparam int unsigned c_ld_cc  = 2;
  localparam int unsigned c_ld_reg = 1;
  localparam int unsigned c_ld_pc  = 0;

  // Bit positions inside the GATE vector {PC, MDR, ALU, MARMUX}
  localparam int unsigned c_gate_pc     = 3;
  localparam int unsigned c_gate_mdr    = 2;
  localparam int unsigned c_gate_alu    = 1;
  localparam int unsigned c_gate_marmux = 0;

  typedef enum logic [4:0] {
    S_HALTED    = 5'd0,
    S_FETCH1    = 5'd1,
    S_FETCH_MEM = 5'd2,
    S_FETCH3    = 5'd3,
    S_PAUSE_IR1 = 5'd4,
    S_PAUSE_IR2 = 5'd5,
    S_DECODE    = 5'd6,
    S_ADD       = 5'd7,
    S_AND       = 5'd8,
    S_NOT       = 5'd9,
    S_BR        = 5'd10,
    S_BR_TAKEN  = 5'd11,
    S_JMP       = 5'd12,
    S_JSR       = 5'd13,
    S_JSR_TGT   = 5'd14,
    S_LDR       = 5'd15,
    S_LDR_MEM   = 5'd16,
    S_LDR_WB    = 5'd17,
    S_STR       = 5'd18,
    S_STR_MDR   = 5'd19,
    S_STR_MEM   = 5'd20,
    S_PAUSE1    = 5'd21,
    S_PAUSE2    = 5'd22
  } state_e;

  // States that hold an SRAM strobe and therefore run the wait counter
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH_MEM) || (s == S_LDR_MEM) || (s == S_STR_MEM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/slc3_mem_wait_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : slc3_mem_wait_ctr                                           |
// | Description: SRAM access wait counter. Counts cycles spent in a memory   |
// |              state; done_o marks the final cycle of the access.          |
// | Ports      : Clk_i   - clock, rising edge                                |
// |              Reset_i - synchronous active-low reset                      |
// |              clr_i   - force count to zero                               |
// |              en_i    - count while not yet done                          |
// |              done_o  - count has reached MEM_WAIT                        |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module slc3_mem_wait_ctr #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned CNT_W    = 4
) (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] c_wait = CNT_W'(MEM_WAIT);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done_o = (cnt_q == c_wait);

  // Saturates at MEM_WAIT; the owning state leaves on that cycle anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + c_one;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/slc3_isdu_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : slc3_isdu_param                                             |
// | Description: SLC-3 instruction sequencer / decode unit. Moore FSM that   |
// |              drives every load, gate, mux and SRAM strobe, with a        |
// |              configurable SRAM latency and optional pause-after-fetch.   |
// | Ports      : Clk_i, Reset_i (sync, active-low), Run_i, Continue_i,       |
// |              BEN_i, Opcode_i[3:0], IR_5_i, IR_11_i in;                   |
// |              LD_o[6:0], GATE_o[3:0], PCMUX_o, DRMUX_o, SR1MUX_o,         |
// |              SR2MUX_o, ADDR1MUX_o, ADDR2MUX_o, ALUK_o, Mem_CE_o,         |
// |              Mem_UB_o, Mem_LB_o, Mem_OE_o, Mem_WE_o, Paused_o out.       |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module slc3_isdu_param
  import slc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT       = 1,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned PAUSE_ON_FETCH = 0
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       Run_i,
  input  logic       Continue_i,
  input  logic       BEN_i,
  input  logic [3:0] Opcode_i,
  input  logic       IR_5_i,
  input  logic       IR_11_i,
  output logic [6:0] LD_o,
  output logic [3:0] GATE_o,
  output logic [1:0] PCMUX_o,
  output logic       DRMUX_o,
  output logic       SR1MUX_o,
  output logic       SR2MUX_o,
  output logic       ADDR1MUX_o,
  output logic [1:0] ADDR2MUX_o,
  output logic [1:0] ALUK_o,
  output logic       Mem_CE_o,
  output logic       Mem_UB_o,
  output logic       Mem_LB_o,
  output logic       Mem_OE_o,
  output logic       Mem_WE_o,
  output logic       Paused_o
);

  state_e state_q;
  state_e state_d;
  logic   w_in_mem;
  logic   w_done;

  assign Mem_CE_o = 1'b0;
  assign Mem_UB_o = 1'b0;
  assign Mem_LB_o = 1'b0;

  // Counter is held at zero outside memory states, so every access starts at 0.
  assign w_in_mem = is_mem_state(state_q);

  slc3_mem_wait_ctr #(
    .MEM_WAIT (MEM_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_ctr (
    .Clk_i   (Clk_i),
    .Reset_i (Reset_i),
    .clr_i   (!w_in_mem),
    .en_i    (w_in_mem),
    .done_o  (w_done)
  );

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state_q <= S_HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    LD_o       = '0;
    GATE_o     = '0;
    PCMUX_o    = c_pcmux_pc1;
    DRMUX_o    = c_drmux_ir11;
    SR1MUX_o   = c_sr1mux_ir11;
    SR2MUX_o   = 1'b0;
    ADDR1MUX_o = c_addr1_pc;
    ADDR2MUX_o = c_addr2_zero;
    ALUK_o     = c_aluk_add;
    Mem_OE_o   = 1'b1;
    Mem_WE_o   = 1'b1;
    Paused_o   = 1'b0;

    unique case (state_q)
      S_HALTED: if (Run_i) state_d = S_FETCH1;
      S_FETCH1: begin
        GATE_o[c_gate_pc] = 1'b1;
        LD_o[c_ld_mar]    = 1'b1;
        LD_o[c_ld_pc]     = 1'b1;
        PCMUX_o           = c_pcmux_pc1;
        state_d           = S_FETCH_MEM;
      end
      S_FETCH_MEM, S_LDR_MEM: begin
        Mem_OE_o = 1'b0;
        // MDR captures only once the SRAM data is valid (last cycle)
        if (w_done) begin
          LD_o[c_ld_mdr] = 1'b1;
          state_d        = (state_q == S_FETCH_MEM) ? S_FETCH3 : S_LDR_WB;
        end
      end
      S_FETCH3: begin
        GATE_o[c_gate_mdr] = 1'b1;
        LD_o[c_ld_ir]      = 1'b1;
        state_d            = (PAUSE_ON_FETCH != 0) ? S_PAUSE_IR1 : S_DECODE;
      end
      S_PAUSE_IR1: begin
        Paused_o = 1'b1;
        if (Continue_i) state_d = S_PAUSE_IR2;
      end
      S_PAUSE_IR2: begin
        Paused_o = 1'b1;
        if (!Continue_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        LD_o[c_ld_ben] = 1'b1;
        case (Opcode_i)
          op_add:   state_d = S_ADD;
          op_and:   state_d = S_AND;
          op_not:   state_d = S_NOT;
          op_br:    state_d = S_BR;
          op_jmp:   state_d = S_JMP;
          op_jsr:   state_d = S_JSR;
          op_ldr:   state_d = S_LDR;
          op_str:   state_d = S_STR;
          op_pause: state_d = S_PAUSE1;
          default:  state_d = S_FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        SR1MUX_o           = c_sr1mux_ir8;
        SR2MUX_o           = IR_5_i;
        ALUK_o             = (state_q == S_ADD) ? c_aluk_add :
                             (state_q == S_AND) ? c_aluk_and : c_aluk_not;
        GATE_o[c_gate_alu] = 1'b1;
        DRMUX_o            = c_drmux_ir11;
        LD_o[c_ld_reg]     = 1'b1;
        LD_o[c_ld_cc]      = 1'b1;
        state_d            = S_FETCH1;
      end
      S_BR: state_d = BEN_i ? S_BR_TAKEN : S_FETCH1;
      S_BR_TAKEN: begin
        ADDR1MUX_o    = c_addr1_pc;
        ADDR2MUX_o    = c_addr2_off9;
        PCMUX_o       = c_pcmux_addr;
        LD_o[c_ld_pc] = 1'b1;
        state_d       = S_FETCH1;
      end
      S_JMP: begin
        SR1MUX_o      = c_sr1mux_ir8;
        ADDR1MUX_o    = c_addr1_sr1;
        ADDR2MUX_o    = c_addr2_zero;
        PCMUX_o       = c_pcmux_addr;
        LD_o[c_ld_pc] = 1'b1;
        state_d       = S_FETCH1;
      end
      S_JSR: begin
        GATE_o[c_gate_pc] = 1'b1;
        DRMUX_o           = c_drmux_r7;
        LD_o[c_ld_reg]    = 1'b1;
        state_d           = S_JSR_TGT;
      end
      S_JSR_TGT: begin
        PCMUX_o       = c_pcmux_addr;
        LD_o[c_ld_pc] = 1'b1;
        SR1MUX_o      = c_sr1mux_ir8;
        // JSR: PC-relative off11; JSRR: base register
        ADDR1MUX_o    = IR_11_i ? c_addr1_pc    : c_addr1_sr1;
        ADDR2MUX_o    = IR_11_i ? c_addr2_off11 : c_addr2_zero;
        state_d       = S_FETCH1;
      end
      S_LDR, S_STR: begin
        SR1MUX_o              = c_sr1mux_ir8;
        ADDR1MUX_o            = c_addr1_sr1;
        ADDR2MUX_o            = c_addr2_off6;
        GATE_o[c_gate_marmux] = 1'b1;
        LD_o[c_ld_mar]        = 1'b1;
        state_d               = (state_q == S_LDR) ? S_LDR_MEM : S_STR_MDR;
      end
      S_LDR_WB: begin
        GATE_o[c_gate_mdr] = 1'b1;
        DRMUX_o            = c_drmux_ir11;
        LD_o[c_ld_reg]     = 1'b1;
        LD_o[c_ld_cc]      = 1'b1;
        state_d            = S_FETCH1;
      end
      S_STR_MDR: begin
        // Source register (IR[11:9]) passed through the ALU into MDR
        SR1MUX_o           = c_sr1mux_ir11;
        ALUK_o             = c_aluk_pass;
        GATE_o[c_gate_alu] = 1'b1;
        LD_o[c_ld_mdr]     = 1'b1;
        state_d            = S_STR_MEM;
      end
      S_STR_MEM: begin
        Mem_WE_o = 1'b0;
        if (w_done) state_d = S_FETCH1;
      end
      S_PAUSE1: begin
        Paused_o = 1'b1;
        if (Continue_i) state_d = S_PAUSE2;
      end
      S_PAUSE2: begin
        Paused_o = 1'b1;
        if (!Continue_i) state_d = S_FETCH1;
      end
      default: state_d = S_HALTED;
    endcase
  end

endmodule
`default_nettype wire
